hex_entry_loader: RTL and testbench



---
 rtl/hex_entry_loader_if.sv | 29 ++
 rtl/hex_entry_loader.sv | 169 ++++++++++++++++
 tb/tb_hex_entry_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_entry_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : hex_entry_loader_if
// Description : Front-panel bundle between the DE10-Lite buttons/switches and
//               the hex nibble loader, plus the assembled value it produces.
//               master = panel/consumer side, slave = loader side.
// Revision    : 1.0 - initial release
// ============================================================================
interface hex_entry_loader_if;
  logic         enter_btn;    // raw, active-low
  logic         clear_btn;    // raw, active-low
  logic [3:0]   switches;
  logic [143:0] data_out;
  logic [5:0]   nib_count;
  logic [2:0]   page;
  logic         data_valid;
  logic         load_strobe;

  modport master (
    output enter_btn, clear_btn, switches,
    input  data_out, nib_count, page, data_valid, load_strobe
  );

  modport slave (
    input  enter_btn, clear_btn, switches,
    output data_out, nib_count, page, data_valid, load_strobe
  );
endinterface
`default_nettype wire

// File: rtl/hex_entry_loader.sv
`default_nettype none
// ============================================================================
// Module      : hex_entry_loader
// Description : Assembles a 144-bit value one hex nibble per enter press,
//               MSB-first, in the 24-bit page order of the 7-segment viewer.
//               A clear press discards everything. data_valid marks all 36
//               nibbles present; load_strobe pulses once when it rises.
// Options     : HEX_ENTRY_DEBOUNCE_EN - when defined, each button level must
//               stay changed for DEBOUNCE_CYCLES clocks before it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_entry_loader #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  hex_entry_loader_if.slave bus
);

  localparam int         DATA_W  = 144;
  localparam logic [5:0] LAST_IX = 6'd35;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Bit 0 = enter, bit 1 = clear throughout the conditioning path.
  logic [1:0] btn_raw;
  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic [1:0] lvl_d;     // accepted (conditioned) level
  logic [1:0] prev_q;    // registered copy of the accepted level
  logic [1:0] press_d;
  logic       enter_evt;
  logic       clear_evt;

  assign btn_raw = {bus.clear_btn, bus.enter_btn};

  // Two-flop synchronizer; idles at 1 (released) so reset creates no press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_btn
`ifdef HEX_ENTRY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;

    assign cnt_d = cnt_q + CNT_W'(1);

    // Accept a new level only after it differs for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b1;
      end else if (sync_q[b] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_d == CNT_W'(DEBOUNCE_CYCLES)) begin
        lvl_q <= sync_q[b];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign lvl_d[b] = lvl_q;
`else
    assign lvl_d[b] = sync_q[b];
`endif
  end

`ifndef HEX_ENTRY_DEBOUNCE_EN
  // The window length only matters with the debouncer present.
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = (DEBOUNCE_CYCLES == 0);
`endif

  // Edge-detect reference for the accepted level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 2'b11;
    end else begin
      prev_q <= lvl_d;
    end
  end

  assign press_d   = prev_q & ~lvl_d;
  assign enter_evt = press_d[0];
  assign clear_evt = press_d[1];

  state_t       state_q;
  logic [143:0] data_q;
  logic [5:0]   nib_count_q;
  logic [5:0]   nib_count_d;
  logic [2:0]   page_q;
  logic         valid_q;
  logic         strobe_q;
  logic [7:0]   wr_lsb_d;

  assign nib_count_d = nib_count_q + 6'd1;
  // Nibble k lands at [143-4k -: 4], i.e. LSB at 140-4k.
  assign wr_lsb_d    = 8'(DATA_W - 4) - {nib_count_q, 2'b00};

  function automatic logic [2:0] page_of(input logic [5:0] n);
    if      (n >= 6'd30) page_of = 3'd5;
    else if (n >= 6'd24) page_of = 3'd4;
    else if (n >= 6'd18) page_of = 3'd3;
    else if (n >= 6'd12) page_of = 3'd2;
    else if (n >= 6'd6)  page_of = 3'd1;
    else                 page_of = 3'd0;
  endfunction

  // Entry FSM with registered outputs; clear takes priority over enter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      nib_count_q <= '0;
      page_q      <= '0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (clear_evt) begin
        state_q     <= EMPTY;
        data_q      <= '0;
        nib_count_q <= '0;
        page_q      <= '0;
        valid_q     <= 1'b0;
      end else if (enter_evt) begin
        case (state_q)
          EMPTY, COLLECT: begin
            data_q[wr_lsb_d +: 4] <= bus.switches;
            nib_count_q           <= nib_count_d;
            page_q                <= page_of(nib_count_d);
            if (nib_count_q == LAST_IX) begin
              state_q  <= FULL;
              valid_q  <= 1'b1;
              strobe_q <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end
          default: begin
            // FULL: further enters are ignored until a clear.
          end
        endcase
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.nib_count   = nib_count_q;
  assign bus.page        = page_q;
  assign bus.data_valid  = valid_q;
  assign bus.load_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_entry_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_entry_loader
// Description : Self-checking bench for hex_entry_loader. A small model of the
//               loader produces expected snapshots queued at each press and
//               popped once the press has been processed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_entry_loader;

  localparam int DEB = 4;
`ifdef HEX_ENTRY_DEBOUNCE_EN
  localparam int EXTRA = DEB;
`else
  localparam int EXTRA = 0;
`endif
  localparam int HOLD = EXTRA + 2;
  localparam int GAP  = 2 * EXTRA + 5;
  localparam int LAT  = 3 + EXTRA;

  typedef struct packed {
    logic [143:0] d;
    logic [5:0]   n;
    logic [2:0]   p;
    logic         v;
  } snap_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  hex_entry_loader_if bus ();

  hex_entry_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int strobe_bad = 0;
  logic prev_valid = 1'b0;

  logic [143:0] m_data;
  int           m_n;
  snap_t        sb[$];

  // Strobe must be high exactly on the cycle data_valid first reads 1.
  always @(negedge clk) begin
    if (bus.load_strobe === 1'b1) strobe_cnt++;
    if (bus.load_strobe !== (bus.data_valid === 1'b1 && prev_valid === 1'b0)) strobe_bad++;
    prev_valid = bus.data_valid;
  end

  function automatic snap_t model_snap();
    snap_t s;
    s.d = m_data;
    s.n = 6'(m_n);
    s.p = (m_n / 6 > 5) ? 3'd5 : 3'(m_n / 6);
    s.v = (m_n == 36);
    return s;
  endfunction

  function automatic snap_t obs();
    snap_t s;
    s = {bus.data_out, bus.nib_count, bus.page, bus.data_valid};
    return s;
  endfunction

  task automatic model_clear();
    m_data = '0;
    m_n    = 0;
  endtask

  task automatic model_enter(input logic [3:0] v);
    if (m_n < 36) begin
      m_data[143 - 4*m_n -: 4] = v;
      m_n++;
    end
  endtask

  // One full press/release; the expected result is queued as it is driven.
  task automatic press(input logic [3:0] v, input bit en, input bit cl);
    @(negedge clk);
    bus.switches  = v;
    bus.enter_btn = en ? 1'b0 : 1'b1;
    bus.clear_btn = cl ? 1'b0 : 1'b1;
    if (cl) model_clear();
    else if (en) model_enter(v);
    sb.push_back(model_snap());
    repeat (HOLD) @(negedge clk);
    bus.enter_btn = 1'b1;
    bus.clear_btn = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_reset();
    snap_t o;
    reset_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    o = obs();
    total++;
    if (o !== model_snap() || bus.load_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got %h strobe %b want %h strobe 0", o, bus.load_strobe, model_snap());
    end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    o = obs();
    total++;
    if (o !== model_snap() || bus.load_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got %h strobe %b want %h strobe 0", o, bus.load_strobe, model_snap());
    end
  endtask

  task automatic test_latency();
    snap_t e, o;
    @(negedge clk);
    bus.switches  = 4'h5;
    bus.enter_btn = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (bus.nib_count !== 6'd0) begin
      bad++;
      $display("FAIL latency_early: got nib_count %0d want 0", bus.nib_count);
    end
    model_enter(4'h5);
    @(negedge clk);
    o = obs();
    e = model_snap();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL latency_on_time: got %h want %h", o, e);
    end
    bus.enter_btn = 1'b1;
    repeat (GAP) @(negedge clk);
    press(4'h0, 1'b0, 1'b1);
    e = sb.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL latency_clear: got %h want %h", o, e);
    end
  endtask

  task automatic test_partial();
    snap_t e, o;
    logic [143:0] want;
    want = {28'hAAAAAAA, 116'd0};
    for (int k = 0; k < 7; k++) begin
      press(4'hA, 1'b1, 1'b0);
      e = sb.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL partial[%0d]: got %h want %h", k, o, e);
      end
    end
    total++;
    if (bus.data_out !== want || bus.nib_count !== 6'd7 || bus.page !== 3'd1) begin
      bad++;
      $display("FAIL partial_final: got %h n=%0d p=%0d want %h n=7 p=1",
               bus.data_out, bus.nib_count, bus.page, want);
    end
    press(4'h0, 1'b0, 1'b1);
    e = sb.pop_front();
    o = obs();
    total++;
    if (o !== e || bus.load_strobe !== 1'b0) begin
      bad++;
      $display("FAIL partial_clear: got %h want %h", o, e);
    end
  endtask

  task automatic test_fill();
    snap_t e, o;
    logic [143:0] want;
    int s0;
    want = 144'h0123456789ABCDEF0123456789ABCDEF0123;
    s0 = strobe_cnt;
    for (int k = 0; k < 36; k++) begin
      press(4'(k % 16), 1'b1, 1'b0);
      e = sb.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL fill[%0d]: got %h want %h", k, o, e);
      end
    end
    total++;
    if (bus.data_out !== want || bus.page !== 3'd5 || bus.data_valid !== 1'b1) begin
      bad++;
      $display("FAIL fill_final: got %h p=%0d v=%b want %h p=5 v=1",
               bus.data_out, bus.page, bus.data_valid, want);
    end
    total++;
    if (strobe_cnt - s0 !== 1 || strobe_bad !== 0) begin
      bad++;
      $display("FAIL fill_strobe: got pulses=%0d misaligned=%0d want pulses=1 misaligned=0",
               strobe_cnt - s0, strobe_bad);
    end
  endtask

  task automatic test_full_ignore();
    snap_t e, o;
    int s0;
    s0 = strobe_cnt;
    for (int k = 0; k < 3; k++) begin
      press(4'hF, 1'b1, 1'b0);
      e = sb.pop_front();
      o = obs();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL full_ignore[%0d]: got %h want %h", k, o, e);
      end
    end
    total++;
    if (strobe_cnt !== s0) begin
      bad++;
      $display("FAIL full_strobe: got %0d extra pulses want 0", strobe_cnt - s0);
    end
  endtask

  task automatic test_simultaneous();
    snap_t e, o;
    press(4'h0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 0; k < 10; k++) begin
      press(4'(k + 3), 1'b1, 1'b0);
      void'(sb.pop_front());
    end
    total++;
    if (bus.nib_count !== 6'd10) begin
      bad++;
      $display("FAIL simul_setup: got nib_count %0d want 10", bus.nib_count);
    end
    press(4'h7, 1'b1, 1'b1);
    e = sb.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL simul_clear_wins: got %h want %h", o, e);
    end
  endtask

`ifdef HEX_ENTRY_DEBOUNCE_EN
  task automatic test_debounce();
    snap_t e, o;
    // 3-cycle glitch: shorter than the window, no event.
    @(negedge clk);
    bus.switches  = 4'h9;
    bus.enter_btn = 1'b0;
    repeat (3) @(negedge clk);
    bus.enter_btn = 1'b1;
    repeat (GAP) @(negedge clk);
    e = model_snap();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL debounce_glitch: got %h want %h", o, e);
    end
    // 5-cycle press followed by a 1-0-1 bounce on release: one nibble.
    @(negedge clk);
    bus.switches  = 4'hC;
    bus.enter_btn = 1'b0;
    model_enter(4'hC);
    sb.push_back(model_snap());
    repeat (5) @(negedge clk);
    bus.enter_btn = 1'b1;
    @(negedge clk);
    bus.enter_btn = 1'b0;
    @(negedge clk);
    bus.enter_btn = 1'b1;
    repeat (GAP) @(negedge clk);
    e = sb.pop_front();
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL debounce_press_bounce: got %h want %h", o, e);
    end
  endtask
`endif

  task automatic test_async_reset();
    snap_t e, o;
    press(4'h0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int k = 0; k < 20; k++) begin
      press(4'(15 - (k % 16)), 1'b1, 1'b0);
      e = sb.pop_front();
    end
    o = obs();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL async_setup: got %h want %h", o, e);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    o = obs();
    total++;
    if (o !== model_snap() || bus.load_strobe !== 1'b0) begin
      bad++;
      $display("FAIL async_immediate: got %h want %h", o, model_snap());
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (GAP + 5) @(negedge clk);
    o = obs();
    total++;
    if (o !== model_snap()) begin
      bad++;
      $display("FAIL async_no_spurious: got %h want %h", o, model_snap());
    end
  endtask

  initial begin
    bus.enter_btn = 1'b1;
    bus.clear_btn = 1'b1;
    bus.switches  = 4'h0;
    model_clear();
    #1;
    test_reset();
    test_latency();
    test_partial();
    test_fill();
    test_full_ignore();
    test_simultaneous();
`ifdef HEX_ENTRY_DEBOUNCE_EN
    test_debounce();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
